// File: rtl/instr_prefetch_unit.sv
// Instruction prefetch: single-outstanding fetch FSM feeding a first-word-fall-through FIFO.
// Optional stall counter output enabled by defining PREFETCH_PERF_COUNT_EN.
module instr_prefetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    input  logic        instr_ready_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i
`ifdef PREFETCH_PERF_COUNT_EN
    ,
    output logic [31:0] stall_cnt_o
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_V = (CNT_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_REQ     = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [31:0]        fetch_pc;
    logic [31:0]        fetch_pc_nxt;
    logic [31:0]        req_pc;
    logic               outstanding;
    logic               outstanding_nxt;
    logic [CNT_W-1:0]   count;
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [31:0]        fifo_instr [DEPTH];
    logic [31:0]        fifo_pc    [DEPTH];

    logic               req;
    logic               xfer;
    logic               push;
    logic               pop;
    logic               not_empty;
    logic [CNT_W:0]     occupancy;
    logic [CNT_W:0]     limit;
    logic               slot_free;

    assign not_empty     = (count != '0);
    assign instr_valid_o = not_empty & ~rst_i;
    assign pop           = instr_valid_o & instr_ready_i;

    // A slot is reserved for every outstanding request; a same-cycle pop frees one.
    assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, outstanding};
    assign limit     = DEPTH_V + {{CNT_W{1'b0}}, pop};
    assign slot_free = (occupancy < limit);

    always_comb begin
        state_nxt       = state;
        fetch_pc_nxt    = fetch_pc;
        outstanding_nxt = outstanding;
        req             = 1'b0;
        xfer            = 1'b0;
        push            = 1'b0;

        case (state)
            ST_REQ: begin
                req  = slot_free;
                xfer = slot_free & imem_gnt_i;
                if (xfer) begin
                    fetch_pc_nxt    = fetch_pc + 32'd4;
                    outstanding_nxt = 1'b1;
                    state_nxt       = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid_i && outstanding) begin
                    push            = 1'b1;
                    outstanding_nxt = 1'b0;
                    state_nxt       = ST_REQ;
                end
            end
            ST_DISCARD: begin
                if (imem_rvalid_i && outstanding) begin
                    outstanding_nxt = 1'b0;
                    state_nxt       = ST_REQ;
                end
            end
            default: begin
                state_nxt       = ST_REQ;
                outstanding_nxt = 1'b0;
            end
        endcase

        // A response still in flight after the redirect must be swallowed in DISCARD;
        // one that lands in the redirect cycle itself is simply dropped.
        if (redirect_i) begin
            push         = 1'b0;
            fetch_pc_nxt = redirect_pc_i & ~32'h3;
            if ((outstanding && !imem_rvalid_i) || xfer) begin
                state_nxt       = ST_DISCARD;
                outstanding_nxt = 1'b1;
            end else begin
                state_nxt       = ST_REQ;
                outstanding_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= ST_REQ;
            fetch_pc    <= RESET_PC & ~32'h3;
            outstanding <= 1'b0;
            count       <= '0;
            head        <= '0;
            tail        <= '0;
        end else begin
            state       <= state_nxt;
            fetch_pc    <= fetch_pc_nxt;
            outstanding <= outstanding_nxt;
            if (redirect_i) begin
                count <= '0;
                head  <= tail;
            end else begin
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
                if (push) tail <= tail + 1'b1;
                if (pop)  head <= head + 1'b1;
            end
        end
    end

    // Datapath storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk_i) begin
        if (xfer) req_pc <= fetch_pc;
        if (push) begin
            fifo_instr[tail] <= imem_rdata_i;
            fifo_pc[tail]    <= req_pc;
        end
    end

    assign imem_req_o  = req & ~rst_i;
    assign imem_addr_o = {fetch_pc[31:2], 2'b00};
    assign instr_o     = instr_valid_o ? fifo_instr[head] : 32'h0;
    assign instr_pc_o  = instr_valid_o ? fifo_pc[head]    : 32'h0;

`ifdef PREFETCH_PERF_COUNT_EN
    logic [31:0] stall_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt <= 32'h0;
        end else if (instr_ready_i && !instr_valid_o && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt;
`endif

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Directed bench for instr_prefetch_unit with a small latency-configurable memory model.
module tb_instr_prefetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
`ifdef PREFETCH_PERF_COUNT_EN
    logic [31:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Memory model: grant follows gnt_en, response arrives lat cycles after the grant.
    logic        gnt_en = 1'b0;
    int          lat = 1;
    logic        pend_v = 1'b0;
    logic [31:0] pend_a = 32'h0;
    int          pend_w = 0;

    always #5 clk = ~clk;

    instr_prefetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_gnt_i    (imem_gnt),
        .imem_rvalid_i (imem_rvalid),
        .imem_rdata_i  (imem_rdata),
        .instr_valid_o (instr_valid),
        .instr_o       (instr),
        .instr_pc_o    (instr_pc),
        .instr_ready_i (instr_ready),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc)
`ifdef PREFETCH_PERF_COUNT_EN
        ,
        .stall_cnt_o   (stall_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic settle();
        #1;
        imem_gnt    = gnt_en & imem_req;
        imem_rvalid = pend_v && (pend_w == 0);
        imem_rdata  = pend_a ^ 32'hA5A5_0000;
        #1;
    endtask

    task automatic step();
        logic        xfer;
        logic        rv;
        logic [31:0] a;
        xfer = imem_req & imem_gnt;
        rv   = imem_rvalid;
        a    = imem_addr;
        @(posedge clk);
        if (rv) pend_v = 1'b0;
        else if (pend_v && pend_w != 0) pend_w--;
        if (xfer) begin
            pend_v = 1'b1;
            pend_a = a;
            pend_w = lat - 1;
        end
        #2;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        redirect = 1'b0;
        settle();
        step();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int grants;
        rst = 1'b1; instr_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;

        // Reset cycle outputs
        settle();
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        chk("rst_valid", {31'h0, instr_valid}, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc", instr_pc, 32'h0);
        step();
        rst = 1'b0;

        // Streaming with immediate grant, 1-cycle response
        instr_ready = 1'b1; gnt_en = 1'b1; lat = 1;
        settle();
        chk("t1_req0", {31'h0, imem_req}, 32'h1);
        chk("t1_addr0", imem_addr, 32'h0);
        step();
        settle();
        chk("t1_wait_req", {31'h0, imem_req}, 32'h0);
        chk("t1_wait_valid", {31'h0, instr_valid}, 32'h0);
        step();
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("t1_valid", {31'h0, instr_valid}, 32'h1);
            chk("t1_pc", instr_pc, 32'(4 * k));
            chk("t1_instr", instr, 32'(4 * k) ^ 32'hA5A5_0000);
            step();
            settle();
            step();
        end

        // Back-pressure: FIFO fills to DEPTH then requests stop
        do_reset();
        instr_ready = 1'b0; gnt_en = 1'b1; lat = 1;
        grants = 0;
        for (int c = 0; c < 16; c++) begin
            settle();
            if (imem_req && imem_gnt) grants++;
            step();
        end
        settle();
        chk("t2_grants", 32'(grants), 32'd4);
        chk("t2_req_full", {31'h0, imem_req}, 32'h0);
        chk("t2_head_pc", instr_pc, 32'h0);
        instr_ready = 1'b1;
        settle();
        chk("t2_req_resume", {31'h0, imem_req}, 32'h1);
        chk("t2_addr_resume", imem_addr, 32'h10);
        step();
        settle();
        chk("t2_next_pc", instr_pc, 32'h4);
        chk("t2_next_instr", instr, 32'hA5A5_0004);

        // Redirect while waiting on a 2-cycle response
        do_reset();
        instr_ready = 1'b1; gnt_en = 1'b1; lat = 2;
        settle(); step();
        redirect = 1'b1; redirect_pc = 32'h0000_0103;
        settle(); step();
        redirect = 1'b0;
        settle();
        chk("t3_valid_after", {31'h0, instr_valid}, 32'h0);
        chk("t3_discard_req", {31'h0, imem_req}, 32'h0);
        step();
        settle();
        chk("t3_dropped", {31'h0, instr_valid}, 32'h0);
        chk("t3_new_addr", imem_addr, 32'h0000_0100);
        chk("t3_new_req", {31'h0, imem_req}, 32'h1);
        step(); settle(); step(); settle(); step();
        settle();
        chk("t3_first_pc", instr_pc, 32'h0000_0100);
        chk("t3_first_instr", instr, 32'hA5A5_0100);

        // Redirect coinciding with grant and pop
        do_reset();
        instr_ready = 1'b0; gnt_en = 1'b1; lat = 1;
        settle(); step(); settle(); step();
        instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h2000_0008;
        settle();
        chk("t4_pre_valid", {31'h0, instr_valid}, 32'h1);
        chk("t4_pre_xfer", {31'h0, imem_req & imem_gnt}, 32'h1);
        step();
        redirect = 1'b0;
        settle();
        chk("t4_flushed", {31'h0, instr_valid}, 32'h0);
        step();
        settle();
        chk("t4_discarded", {31'h0, instr_valid}, 32'h0);
        chk("t4_restart_addr", imem_addr, 32'h2000_0008);
        step(); settle(); step();
        settle();
        chk("t4_first_pc", instr_pc, 32'h2000_0008);
        chk("t4_first_instr", instr, 32'h85A5_0008);

        // Redirect without grant, then fetch PC wraps at 2^32
        gnt_en = 1'b0; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        settle(); step();
        redirect = 1'b0; gnt_en = 1'b1;
        settle();
        chk("t6_valid", {31'h0, instr_valid}, 32'h0);
        chk("t6_addr", imem_addr, 32'hFFFF_FFFC);
        step(); settle(); step();
        settle();
        chk("t6_wrap_addr", imem_addr, 32'h0);
        chk("t6_pc", instr_pc, 32'hFFFF_FFFC);
        chk("t6_instr", instr, 32'h5A5A_FFFC);
        step();

        // Reset with a request outstanding and three buffered entries
        do_reset();
        instr_ready = 1'b0; gnt_en = 1'b1; lat = 2;
        for (int c = 0; c < 10; c++) begin
            settle(); step();
        end
        settle();
        chk("t5_pre_valid", {31'h0, instr_valid}, 32'h1);
        chk("t5_pre_req", {31'h0, imem_req}, 32'h0);
        rst = 1'b1;
        settle();
        chk("t5_rst_req", {31'h0, imem_req}, 32'h0);
        chk("t5_rst_valid", {31'h0, instr_valid}, 32'h0);
        chk("t5_rst_instr", instr, 32'h0);
        chk("t5_rst_pc", instr_pc, 32'h0);
        step();
        rst = 1'b0;
        settle();
        chk("t5_stray_seen", {31'h0, imem_rvalid}, 32'h1);
        chk("t5_restart_addr", imem_addr, 32'h0);
        chk("t5_restart_req", {31'h0, imem_req}, 32'h1);
        step();
        settle();
        chk("t5_stray_dropped", {31'h0, instr_valid}, 32'h0);
        step(); settle(); step();
        settle();
        chk("t5_first_pc", instr_pc, 32'h0);

`ifdef PREFETCH_PERF_COUNT_EN
        do_reset();
        instr_ready = 1'b1; gnt_en = 1'b0;
        for (int c = 0; c < 10; c++) begin
            settle(); step();
        end
        settle();
        chk("perf_stall", stall_cnt, 32'd10);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_prefetch_unit.md
Name: instr_prefetch_unit

Overview:
- Fetch stage directly upstream of the single-cycle decode/execute datapath.
- Maintains the fetch PC and issues word requests to instruction memory over a req/gnt/rvalid handshake.
- Buffers returned words, each with its PC, in a small FIFO.
- Presents instructions to the core through a valid/ready interface; supports redirect (branch/jump) with flush.

Parameters:
DEPTH, 4, FIFO entries (power of two, 2..16)
RESET_PC, 32'h0000_0000, fetch PC loaded on reset (word-aligned)

Ports:
clk_i  input  1  clock; all state updates on rising edge
rst_i  input  1  reset; one clock; reset is synchronous and active-high
imem_req_o  output  1  fetch request
imem_addr_o  output  32  fetch address, bits [1:0] always 0
imem_gnt_i  input  1  memory accepts request this cycle
imem_rvalid_i  input  1  read data valid
imem_rdata_i  input  32  read data
instr_valid_o  output  1  FIFO head valid
instr_o  output  32  head instruction word
instr_pc_o  output  32  PC of head instruction
instr_ready_i  input  1  core consumes head
redirect_i  input  1  flush and restart fetch
redirect_pc_i  input  32  new fetch PC; bits [1:0] ignored, forced 0

Behaviour:
- Reset (rst_i=1 at edge): state=REQ, fetch_pc=RESET_PC, FIFO count=0, outstanding=0, head/tail pointers=0.
- During the reset cycle: imem_req_o=0, instr_valid_o=0, instr_o=0, instr_pc_o=0.
- Reset mid-operation discards everything. Any rvalid in the following cycle is ignored, because outstanding=0.
- FSM states:
  - REQ: imem_req_o=1 iff count+outstanding < DEPTH (slot reservation; FIFO can never overflow). imem_addr_o=fetch_pc. On req&gnt: fetch_pc+=4, outstanding=1, go to WAIT.
  - WAIT: imem_req_o=0. At most one request is outstanding. On rvalid: push {fetch_pc_of_req, rdata}, outstanding=0, go to REQ.
  - DISCARD: imem_req_o=0. On rvalid: drop data, outstanding=0, go to REQ.
- Memory protocol:
  - rvalid arrives no earlier than the cycle after gnt.
  - req may be withdrawn before gnt; only the gnt cycle is a transfer.
  - rvalid while outstanding=0 is ignored.
- FIFO:
  - First-word-fall-through: instr_valid_o = (count≠0); instr_o and instr_pc_o are driven from the head entry, and are 0 when empty.
  - Pop on instr_valid_o & instr_ready_i.
  - A push in cycle t is visible on instr_valid_o at t+1.
  - Simultaneous push and pop: count unchanged.
  - Pointers wrap modulo DEPTH.
- Redirect (redirect_i=1 at edge), highest priority after reset:
  - count=0 and any pop that cycle is ignored; fetch_pc=redirect_pc_i & ~3.
  - If outstanding=1, or req&gnt in the same cycle: go to DISCARD.
  - Otherwise go to REQ; the new address appears the next cycle.
  - An rvalid in the redirect cycle is dropped.
  - instr_valid_o=0 the cycle after a redirect.
- fetch_pc increment wraps at 2^32 (0xFFFF_FFFC + 4 = 0).
- Throughput: one instruction per 2 cycles at best (REQ→WAIT with 1-cycle memory).

Optional Feature:
- Macro PREFETCH_PERF_COUNT_EN.
- Defined: adds output port stall_cnt_o [31:0]. It counts cycles with instr_ready_i=1 and instr_valid_o=0, resets to 0 on rst_i, saturates at 0xFFFF_FFFF, and does not clear on redirect.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset release, RESET_PC=0, memory gnt immediate with rvalid 1 cycle later returning addr^32'hA5A5_0000, ready=1:
  - first req at addr 0 in the first post-reset cycle;
  - instr_valid_o with instr_pc_o=0, instr_o=32'hA5A5_0000 two cycles after gnt;
  - subsequent PCs 4, 8, 12.
- instr_ready_i=0, DEPTH=4:
  - exactly 4 grants, then imem_req_o stays 0; count=4, no overflow;
  - raise ready: req resumes in the same cycle as the first pop.
- Redirect to 32'h0000_0103 while in WAIT:
  - next rvalid dropped;
  - next request addr 32'h0000_0100;
  - first delivered instr_pc_o=32'h100;
  - instr_valid_o=0 the cycle after redirect.
- Redirect coinciding with req&gnt and with a pop of a non-empty FIFO:
  - FIFO empty next cycle;
  - granted response discarded;
  - fetch restarts at redirect_pc.
- rst_i asserted while outstanding=1 with FIFO holding 3 entries:
  - outputs 0 in the reset cycle;
  - a stray rvalid next cycle is not pushed;
  - fetch restarts at RESET_PC.
- PREFETCH_PERF_COUNT_EN defined, memory gnt held 0 for 10 cycles with ready=1 after reset: stall_cnt_o=10 at the end.
